// File: rtl/cp0_compare_timer.sv
// CP0 Compare register and timer-interrupt sequencer (IDLE -> PENDING -> SERVICED).
// Optional lost-match counter enabled by defining CP0_TIMER_MISS_CNT_EN.
module cp0_compare_timer #(
  parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF,
  parameter int unsigned IRQ_LINE    = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] count,
  input  logic        count_write,
  input  logic        compare_write,
  input  logic [31:0] compare_in,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic        status_im,
  input  logic        irq_ack,
  output logic [31:0] compare,
  output logic        ti,
  output logic        irq_req,
  output logic [2:0]  ip_idx,
  output logic [7:0]  miss_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PENDING  = 2'd1,
    SERVICED = 2'd2
  } state_t;

  localparam logic [2:0] IP_IDX = 3'(IRQ_LINE);

  state_t      state_q, state_d;
  logic [31:0] compare_q, compare_d;
  logic        eq_q, eq_d;
  logic        eq;
  logic        match;

  // Edge-detected equality: a Count parked on Compare fires only once.
  always_comb begin
    eq    = (count == compare_q);
    match = eq & ~eq_q & ~count_write & ~compare_write;
  end

  // A Compare write re-arms with eq_q set, so a Compare equal to the
  // current Count waits for Count to leave and come back.
  always_comb begin
    compare_d = compare_q;
    eq_d      = eq;
    if (compare_write) begin
      compare_d = compare_in;
      eq_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      compare_q <= COMPARE_RST;
      eq_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      compare_q <= compare_d;
      eq_q      <= eq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (compare_write) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (match) state_d = PENDING;
        PENDING:  if (irq_ack && irq_req) state_d = SERVICED;
        SERVICED: state_d = SERVICED;
        default:  state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ti      = (state_q != IDLE);
    irq_req = (state_q == PENDING) & status_ie & status_im & ~status_exl;
  end

  assign compare = compare_q;
  assign ip_idx  = IP_IDX;

`ifdef CP0_TIMER_MISS_CNT_EN
  logic [7:0] miss_cnt_q, miss_cnt_d;
  logic       lost_match;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    lost_match = match & (state_q != IDLE);
    miss_cnt_d = miss_cnt_q;
    if (compare_write) begin
      miss_cnt_d = 8'h00;
    end else if (lost_match) begin
      miss_cnt_d = sat_inc8(miss_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      miss_cnt_q <= 8'h00;
    end else begin
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign miss_cnt = miss_cnt_q;
`else
  assign miss_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_cp0_compare_timer.sv
// Randomized + directed bench for cp0_compare_timer against an event-level model
// of the timer interrupt (armed/pending/acknowledged flags).
module tb_cp0_compare_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] count;
  logic        count_write;
  logic        compare_write;
  logic [31:0] compare_in;
  logic        status_ie, status_exl, status_im;
  logic        irq_ack;
  logic [31:0] compare;
  logic        ti, irq_req;
  logic [2:0]  ip_idx;
  logic [7:0]  miss_cnt;

  always #5 clk = ~clk;

  cp0_compare_timer dut (
    .clk(clk), .reset(reset), .count(count), .count_write(count_write),
    .compare_write(compare_write), .compare_in(compare_in),
    .status_ie(status_ie), .status_exl(status_exl), .status_im(status_im),
    .irq_ack(irq_ack), .compare(compare), .ti(ti), .irq_req(irq_req),
    .ip_idx(ip_idx), .miss_cnt(miss_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: Compare value, whether Count sat on Compare last cycle,
  // whether an interrupt is outstanding and whether it was already taken.
  logic [31:0] m_cmp;
  bit          m_on_cmp;
  bit          m_pend;
  bit          m_taken;
  int          m_miss;
  bit          s_ie, s_im, s_exl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cmp    = 32'hFFFF_FFFF;
    m_on_cmp = 1'b1;
    m_pend   = 1'b0;
    m_taken  = 1'b0;
    m_miss   = 0;
  endtask

  // One clock: drive inputs at negedge, check outputs, advance the model.
  task automatic step(input bit rst, input logic [31:0] cnt, input bit cntw,
                      input bit cw, input logic [31:0] cin, input bit ack);
    bit exp_irq;
    bit fire;
    @(negedge clk);
    reset = rst; count = cnt; count_write = cntw; compare_write = cw;
    compare_in = cin; irq_ack = ack;
    status_ie = s_ie; status_im = s_im; status_exl = s_exl;
    #1;
    exp_irq = m_pend && !m_taken && s_ie && s_im && !s_exl;
    chk("ti", {31'd0, ti}, {31'd0, m_pend});
    chk("irq_req", {31'd0, irq_req}, {31'd0, exp_irq});
    chk("compare", compare, m_cmp);
    chk("miss_cnt", {24'd0, miss_cnt}, 32'(m_miss));
    fire = (cnt == m_cmp) && !m_on_cmp && !cntw && !cw;
    if (rst) begin
      model_reset();
    end else if (cw) begin
      m_cmp = cin; m_pend = 0; m_taken = 0; m_on_cmp = 1; m_miss = 0;
    end else begin
      m_on_cmp = (cnt == m_cmp);
      if (fire && !m_pend) m_pend = 1;
`ifdef CP0_TIMER_MISS_CNT_EN
      else if (fire && m_miss < 255) m_miss++;
`endif
      if (exp_irq && ack) m_taken = 1;
    end
  endtask

  task automatic tick(input logic [31:0] cnt);
    step(0, cnt, 0, 0, 32'd0, 0);
  endtask

  logic [31:0] c;
  logic [31:0] base;

  initial begin
    s_ie = 1; s_im = 1; s_exl = 0;
    reset = 1; count = 0; count_write = 0; compare_write = 0;
    compare_in = 0; irq_ack = 0;
    status_ie = 1; status_im = 1; status_exl = 0;
    repeat (2) @(posedge clk);
    model_reset();

    chk("ip_idx", {29'd0, ip_idx}, 32'd7);

    // Basic match at 0x10.
    step(0, 32'd0, 0, 1, 32'h10, 0);
    for (int i = 0; i <= 32'h12; i++) tick(32'(i));
    chk("basic_ti", {31'd0, ti}, 32'd1);
    chk("basic_irq", {31'd0, irq_req}, 32'd1);

    // Acknowledge then rewrite Compare.
    step(0, 32'h13, 0, 0, 0, 1);
    tick(32'h14);
    chk("ack_irq", {31'd0, irq_req}, 32'd0);
    chk("ack_ti", {31'd0, ti}, 32'd1);
    step(0, 32'h15, 0, 1, 32'h40, 0);
    tick(32'h16);
    chk("cw_ti", {31'd0, ti}, 32'd0);

    // EXL masking while pending.
    for (int i = 32'h17; i <= 32'h41; i++) tick(32'(i));
    s_exl = 1; tick(32'h42);
    chk("exl_irq", {31'd0, irq_req}, 32'd0);
    chk("exl_ti", {31'd0, ti}, 32'd1);
    s_exl = 0; tick(32'h43);
    chk("exl_drop_irq", {31'd0, irq_req}, 32'd1);

    // Held Count fires once; same-cycle write beats a match.
    step(0, 32'h1F, 0, 1, 32'h20, 0);
    tick(32'h1F);
    repeat (5) tick(32'h20);
    chk("hold_ti", {31'd0, ti}, 32'd1);
    chk("hold_miss", {24'd0, miss_cnt}, 32'd0);
    step(0, 32'h2E, 0, 1, 32'h30, 0);
    tick(32'h2F);
    step(0, 32'h30, 0, 1, 32'h30, 0);
    tick(32'h30);
    chk("cw_beats_match", {31'd0, ti}, 32'd0);
    tick(32'h31);
    tick(32'h30);
    tick(32'h31);
    chk("rearm_ti", {31'd0, ti}, 32'd1);

    // Lost matches while SERVICED.
    step(0, 32'h32, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      tick(32'h30);
      tick(32'h31);
    end
`ifdef CP0_TIMER_MISS_CNT_EN
    chk("miss3", {24'd0, miss_cnt}, 32'd3);
`else
    chk("miss_off", {24'd0, miss_cnt}, 32'd0);
`endif
    step(0, 32'h31, 0, 1, 32'h50, 0);
    tick(32'h31);
    chk("miss_clr", {24'd0, miss_cnt}, 32'd0);

    // Wrap through zero.
    step(0, 32'hFFFF_FFFE, 0, 1, 32'h0, 0);
    tick(32'hFFFF_FFFF);
    tick(32'h0);
    tick(32'h1);
    chk("wrap_ti", {31'd0, ti}, 32'd1);

    // Reset while pending.
    step(1, 32'h2, 0, 0, 0, 0);
    tick(32'h3);
    chk("rst_ti", {31'd0, ti}, 32'd0);
    chk("rst_irq", {31'd0, irq_req}, 32'd0);
    chk("rst_cmp", compare, 32'hFFFF_FFFF);

    // Randomized traffic.
    c = 32'h100;
    step(0, c, 0, 1, c + 32'd5, 0);
    for (int n = 0; n < 3000; n++) begin
      int r;
      bit cntw, cw, ack, rst;
      logic [31:0] cin;
      r = int'($urandom_range(0, 15));
      cntw = 0;
      if (r < 9) c = c + 1;
      else if (r < 11) c = c;
      else if (r == 11) c = m_cmp - 32'd1;
      else if (r == 12) c = m_cmp;
      else if (r == 13) begin c = $urandom; cntw = 1; end
      else c = c - 1;
      cw   = ($urandom_range(0, 39) == 0);
      base = c;
      cin  = base + 32'($urandom_range(0, 6));
      ack  = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 299) == 0);
      s_ie  = ($urandom_range(0, 7) != 0);
      s_im  = ($urandom_range(0, 7) != 0);
      s_exl = ($urandom_range(0, 5) == 0);
      step(rst, c, cntw, cw, cin, ack);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
